xspi_mem_responder: RTL and testbench



---
 rtl/xspi_pkg.sv | 22 ++
 rtl/xspi_sync.sv | 27 ++
 rtl/xspi_sync_edge.sv | 37 +++
 rtl/xspi_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_xspi_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xspi_pkg.sv
// rtl/xspi_pkg.sv - opcodes, FSM states and protocol constants shared by the xSPI responder
package xspi_pkg;

    localparam logic [7:0] OPC_WREN    = 8'h06;
    localparam logic [7:0] OPC_WRDI    = 8'h04;
    localparam logic [7:0] OPC_RDSR    = 8'h05;
    localparam logic [7:0] OPC_READ    = 8'h0B;
    localparam logic [7:0] OPC_PROGRAM = 8'h12;

    localparam int ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/xspi_sync.sv
// rtl/xspi_sync.sv - two-flop synchronizer for signals arriving from the host clock domain
module xspi_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/xspi_sync_edge.sv
// rtl/xspi_sync_edge.sv - synchronizer plus registered rise/fall pulses for the host serial clock
module xspi_sync_edge (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic w_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    xspi_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_sync (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_d      (i_d),
        .o_q      (w_sync)
    );

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= w_sync;
            r_rise <= w_sync & ~r_prev;
            r_fall <= ~w_sync & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/xspi_mem_responder.sv
// rtl/xspi_mem_responder.sv - octal SPI memory-side responder serving READ/PROGRAM/RDSR from a byte array
module xspi_mem_responder
    import xspi_pkg::*;
#(
    parameter int MEM_DQ_BUS_WIDTH = 8,
    parameter int MEM_DEPTH_LOG2   = 8,
    parameter int DUMMY_CYCLES     = 8
) (
    input  logic                        mem_clk,
    input  logic                        mem_rst_n,
    input  logic                        cs_n_i,
    input  logic                        sclk_i,
    input  logic [MEM_DQ_BUS_WIDTH-1:0] dq_in_i,
    output logic [MEM_DQ_BUS_WIDTH-1:0] dq_out_o,
    output logic                        dq_oe_o,
    output logic                        dqs_o,
    output logic                        cmd_err_o
);

    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    logic                        w_cs_n;
    logic                        w_sclk_rise;
    logic                        w_sclk_fall;
    logic [MEM_DQ_BUS_WIDTH-1:0] w_dq;
    logic [MEM_DQ_BUS_WIDTH-1:0] w_status;
    logic [MEM_DQ_BUS_WIDTH-1:0] w_rd_byte;
    logic                        w_mem_we;

    state_t                      r_state;
    logic [7:0]                  r_opcode;
    logic [1:0]                  r_byte_cnt;
    logic [7:0]                  r_cnt;
    logic [MEM_DEPTH_LOG2-1:0]   r_ptr;
    logic                        r_wel;
    logic [MEM_DQ_BUS_WIDTH-1:0] r_dq_out;
    logic                        r_dq_oe;
    logic                        r_dqs;
    logic                        r_cmd_err;
    logic [MEM_DQ_BUS_WIDTH-1:0] r_mem [0:DEPTH-1];

    xspi_sync_edge u_sclk (
        .i_clk    (mem_clk),
        .i_resetn (mem_rst_n),
        .i_d      (sclk_i),
        .o_rise   (w_sclk_rise),
        .o_fall   (w_sclk_fall)
    );

    // CS_N resets high so the FSM does not see a phantom select while the chain fills.
    xspi_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_cs (
        .i_clk    (mem_clk),
        .i_resetn (mem_rst_n),
        .i_d      (cs_n_i),
        .o_q      (w_cs_n)
    );

    xspi_sync #(.WIDTH(MEM_DQ_BUS_WIDTH)) u_dq (
        .i_clk    (mem_clk),
        .i_resetn (mem_rst_n),
        .i_d      (dq_in_i),
        .o_q      (w_dq)
    );

    assign w_status  = {{(MEM_DQ_BUS_WIDTH-2){1'b0}}, r_wel, 1'b0};
    assign w_rd_byte = r_mem[r_ptr];
    assign w_mem_we  = (r_state == ST_WDATA) && !w_cs_n && w_sclk_rise && r_wel;

    always_ff @(posedge mem_clk) begin
        if (!mem_rst_n) begin
            r_state    <= ST_IDLE;
            r_opcode   <= '0;
            r_byte_cnt <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_wel      <= 1'b0;
            r_dq_out   <= '0;
            r_dq_oe    <= 1'b0;
            r_dqs      <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            if (w_cs_n) begin
                // Deselect commits the write-enable latch for the transaction just ended.
                if (r_state != ST_IDLE && r_byte_cnt != 2'd0) begin
                    case (r_opcode)
                        OPC_WREN:              if (r_byte_cnt == 2'd1) r_wel <= 1'b1;
                        OPC_WRDI, OPC_PROGRAM: r_wel <= 1'b0;
                        default:               ;
                    endcase
                end
                r_state  <= ST_IDLE;
                r_dq_oe  <= 1'b0;
                r_dqs    <= 1'b0;
                r_dq_out <= '0;
            end else begin
                if (w_sclk_rise && r_byte_cnt != 2'd3)
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_CMD;
                        r_byte_cnt <= '0;
                        r_opcode   <= '0;
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_opcode <= w_dq;
                            r_cnt    <= '0;
                            case (w_dq)
                                OPC_WREN, OPC_WRDI:    r_state <= ST_IGNORE;
                                OPC_RDSR:              r_state <= ST_RDATA;
                                OPC_READ, OPC_PROGRAM: r_state <= ST_ADDR;
                                default: begin
                                    r_cmd_err <= 1'b1;
                                    r_state   <= ST_IGNORE;
                                end
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        // Only the low address bits survive the shift; upper bytes fall off the top.
                        if (w_sclk_rise) begin
                            r_ptr <= MEM_DEPTH_LOG2'({r_ptr, w_dq});
                            if (r_cnt == 8'(ADDR_BYTES - 1)) begin
                                r_cnt <= '0;
                                if (r_opcode == OPC_PROGRAM)
                                    r_state <= ST_WDATA;
                                else if (DUMMY_CYCLES == 0)
                                    r_state <= ST_RDATA;
                                else
                                    r_state <= ST_DUMMY;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (w_sclk_rise) begin
                            if (r_cnt == 8'(DUMMY_CYCLES - 1))
                                r_state <= ST_RDATA;
                            else
                                r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    ST_RDATA: begin
                        if (w_sclk_fall) begin
                            r_dq_oe <= 1'b1;
                            r_dqs   <= ~r_dqs;
                            if (r_opcode == OPC_RDSR) begin
                                r_dq_out <= w_status;
                            end else begin
                                r_dq_out <= w_rd_byte;
                                r_ptr    <= r_ptr + 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_sclk_rise)
                            r_ptr <= r_ptr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge mem_clk) begin
        if (!mem_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= w_dq;
        end
    end

    assign dq_out_o  = r_dq_out;
    assign dq_oe_o   = r_dq_oe;
    assign dqs_o     = r_dqs;
    assign cmd_err_o = r_cmd_err;

endmodule

// File: tb/tb_xspi_mem_responder.sv
// tb/tb_xspi_mem_responder.sv - randomized self-checking bench for the xSPI memory responder
module tb_xspi_mem_responder;

    localparam logic [7:0] C_WREN = 8'h06;
    localparam logic [7:0] C_WRDI = 8'h04;
    localparam logic [7:0] C_RDSR = 8'h05;
    localparam logic [7:0] C_READ = 8'h0B;
    localparam logic [7:0] C_PROG = 8'h12;

    logic       mem_clk = 1'b0;
    logic       mem_rst_n;
    logic       cs_n;
    logic       sclk;
    logic [7:0] dq_in;
    logic [7:0] dq_out;
    logic       dq_oe;
    logic       dqs;
    logic       cmd_err;

    always #5 mem_clk = ~mem_clk;

    xspi_mem_responder #(
        .MEM_DQ_BUS_WIDTH (8),
        .MEM_DEPTH_LOG2   (8),
        .DUMMY_CYCLES     (8)
    ) dut (
        .mem_clk   (mem_clk),
        .mem_rst_n (mem_rst_n),
        .cs_n_i    (cs_n),
        .sclk_i    (sclk),
        .dq_in_i   (dq_in),
        .dq_out_o  (dq_out),
        .dq_oe_o   (dq_oe),
        .dqs_o     (dqs),
        .cmd_err_o (cmd_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int err_total = 0;
    int oe_total  = 0;

    always @(negedge mem_clk) begin
        if (cmd_err) err_total++;
        if (dq_oe)   oe_total++;
    end

    logic [7:0] m_mem [0:255];
    logic       m_wel;

    logic [7:0] wbuf   [0:7];
    logic [7:0] rbuf   [0:7];
    logic       oebuf  [0:7];
    logic       dqsbuf [0:7];
    logic       pre_oe;
    logic       oe_at2, oe_at3, dqs_at3;
    int         err_d, oe_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic oe, output logic ds);
        dq_in = tx;
        repeat (6) @(negedge mem_clk);
        rx = dq_out;
        oe = dq_oe;
        ds = dqs;
        sclk = 1'b1;
        repeat (4) @(negedge mem_clk);
        sclk = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (4) @(negedge mem_clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge mem_clk);
        cs_n = 1'b1;
        repeat (2) @(negedge mem_clk);
        oe_at2 = dq_oe;
        @(negedge mem_clk);
        oe_at3  = dq_oe;
        dqs_at3 = dqs;
        repeat (3) @(negedge mem_clk);
    endtask

    // Header length follows from the opcode: opcode, 4 address bytes, 8 dummy cycles for READ.
    task automatic send_bytes(input logic [7:0] opc, input logic [31:0] addr, input int ndata, input int nlimit);
        int nhdr;
        logic [7:0] tx, rx;
        logic oe, ds;
        nhdr = 1;
        if (opc == C_READ || opc == C_PROG) nhdr += 4;
        if (opc == C_READ) nhdr += 8;
        pre_oe = 1'b0;
        for (int k = 0; k < nhdr + ndata && k < nlimit; k++) begin
            if (k == 0)                  tx = opc;
            else if (k >= nhdr)          tx = wbuf[k - nhdr];
            else if (k <= 4 && nhdr > 1) tx = addr[8*(4-k) +: 8];
            else                         tx = 8'($urandom);
            xfer(tx, rx, oe, ds);
            if (k >= nhdr) begin
                rbuf[k - nhdr]   = rx;
                oebuf[k - nhdr]  = oe;
                dqsbuf[k - nhdr] = ds;
            end else if (oe) begin
                pre_oe = 1'b1;
            end
        end
    endtask

    task automatic run_txn(input logic [7:0] opc, input logic [31:0] addr, input int ndata, input int nlimit);
        int e0, o0;
        e0 = err_total;
        o0 = oe_total;
        cs_low();
        send_bytes(opc, addr, ndata, nlimit);
        cs_high();
        err_d = err_total - e0;
        oe_d  = oe_total - o0;
    endtask

    task automatic check_txn(input string tag, input logic [7:0] opc, input logic [31:0] addr, input int ndata);
        logic [7:0] a, exp;
        bit is_rd, is_bad;
        is_rd  = (opc == C_READ) || (opc == C_RDSR);
        is_bad = !(opc inside {C_WREN, C_WRDI, C_RDSR, C_READ, C_PROG});
        if (is_rd) begin
            for (int i = 0; i < ndata; i++) begin
                a   = addr[7:0] + 8'(i);
                exp = (opc == C_RDSR) ? {6'b0, m_wel, 1'b0} : m_mem[a];
                check($sformatf("%s_rd%0d", tag, i),  32'(rbuf[i]),   32'(exp));
                check($sformatf("%s_dqs%0d", tag, i), 32'(dqsbuf[i]), 32'((i + 1) % 2));
                check($sformatf("%s_oe%0d", tag, i),  32'(oebuf[i]),  32'd1);
            end
            check({tag, "_pre_oe"},  32'(pre_oe), 32'd0);
            check({tag, "_oe_hold"}, 32'(oe_at2), 32'd1);
        end else begin
            check({tag, "_oe_quiet"}, 32'(oe_d), 32'd0);
        end
        check({tag, "_err"},     32'(err_d),   is_bad ? 32'd1 : 32'd0);
        check({tag, "_oe_off"},  32'(oe_at3),  32'd0);
        check({tag, "_dqs_off"}, 32'(dqs_at3), 32'd0);
    endtask

    task automatic model_update(input logic [7:0] opc, input logic [31:0] addr, input int ndata);
        logic [7:0] a;
        case (opc)
            C_WREN: if (ndata == 0) m_wel = 1'b1;
            C_WRDI: m_wel = 1'b0;
            C_PROG: begin
                for (int i = 0; i < ndata; i++) begin
                    a = addr[7:0] + 8'(i);
                    if (m_wel) m_mem[a] = wbuf[i];
                end
                m_wel = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic txn(input string tag, input logic [7:0] opc, input logic [31:0] addr, input int ndata);
        run_txn(opc, addr, ndata, 64);
        check_txn(tag, opc, addr, ndata);
        model_update(opc, addr, ndata);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_wel = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  op;
        logic [31:0] ad;
        int          nd, sel;

        model_reset();
        mem_rst_n = 1'b0;
        cs_n      = 1'b1;
        sclk      = 1'b0;
        dq_in     = 8'h00;
        repeat (3) @(negedge mem_clk);
        check("rst_dq_out",  32'(dq_out),  32'd0);
        check("rst_dq_oe",   32'(dq_oe),   32'd0);
        check("rst_dqs",     32'(dqs),     32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        mem_rst_n = 1'b1;
        repeat (4) @(negedge mem_clk);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        txn("wren1", C_WREN, 32'h0, 0);
        txn("prog10", C_PROG, 32'h0000_0010, 2);
        txn("read10", C_READ, 32'h0000_0010, 2);
        check("read10_b0", 32'(rbuf[0]), 32'hA5);
        check("read10_b1", 32'(rbuf[1]), 32'h5A);

        wbuf[0] = 8'h33;
        txn("prog20_nowel", C_PROG, 32'h0000_0020, 1);
        txn("read20", C_READ, 32'h0000_0020, 1);
        check("read20_b0", 32'(rbuf[0]), 32'h00);
        txn("rdsr_off", C_RDSR, 32'h0, 1);
        check("rdsr_off_b0", 32'(rbuf[0]), 32'h00);

        txn("wren2", C_WREN, 32'h0, 0);
        txn("rdsr_on", C_RDSR, 32'h0, 3);
        check("rdsr_on_b2", 32'(rbuf[2]), 32'h02);
        wbuf[0] = 8'h77;
        txn("prog30", C_PROG, 32'h0000_0030, 1);
        txn("rdsr_after", C_RDSR, 32'h0, 1);
        check("rdsr_after_b0", 32'(rbuf[0]), 32'h00);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        txn("wren3", C_WREN, 32'h0, 0);
        txn("prog_wrap", C_PROG, 32'h0000_00FF, 2);
        txn("read_wrap", C_READ, 32'h0000_00FF, 2);
        check("read_wrap_b0", 32'(rbuf[0]), 32'h11);
        check("read_wrap_b1", 32'(rbuf[1]), 32'h22);

        txn("bad9f", 8'h9F, 32'h0, 0);
        txn("read_after_bad", C_READ, 32'h0000_0010, 2);
        check("read_after_bad_b0", 32'(rbuf[0]), 32'hA5);

        // Abort mid-address: array untouched, PROGRAM still drops the write-enable latch.
        txn("wren4", C_WREN, 32'h0, 0);
        wbuf[0] = 8'hEE; wbuf[1] = 8'hEE;
        run_txn(C_PROG, 32'h0000_0010, 2, 3);
        m_wel = 1'b0;
        txn("read_abort", C_READ, 32'h0000_0010, 2);
        check("read_abort_b1", 32'(rbuf[1]), 32'h5A);

        // Abort mid-data: first byte lands, the unclocked second byte does not.
        txn("wren5", C_WREN, 32'h0, 0);
        wbuf[0] = 8'h6C; wbuf[1] = 8'hC6;
        run_txn(C_PROG, 32'h0000_0040, 2, 6);
        model_update(C_PROG, 32'h0000_0040, 1);
        txn("read_partial", C_READ, 32'h0000_0040, 2);
        check("read_partial_b1", 32'(rbuf[1]), 32'h00);

        cs_low();
        send_bytes(C_READ, 32'h0000_0010, 0, 64);
        repeat (6) @(negedge mem_clk);
        check("mid_rd_oe",  32'(dq_oe), 32'd1);
        check("mid_rd_dqs", 32'(dqs),   32'd1);
        mem_rst_n = 1'b0;
        @(negedge mem_clk);
        check("mid_rst_oe",  32'(dq_oe),  32'd0);
        check("mid_rst_dqs", 32'(dqs),    32'd0);
        check("mid_rst_dq",  32'(dq_out), 32'd0);
        cs_n = 1'b1;
        repeat (3) @(negedge mem_clk);
        mem_rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge mem_clk);
        txn("read_post_rst", C_READ, 32'h0000_0010, 1);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            ad = $urandom;
            if ($urandom_range(0, 1) == 1) ad[7:0] = 8'hFC + 8'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            case (sel)
                0: begin op = C_WREN; nd = (($urandom_range(0, 3) == 0) ? 1 : 0); end
                1: begin op = C_WRDI; nd = $urandom_range(0, 1); end
                2: begin op = C_RDSR; nd = $urandom_range(1, 3); end
                3: begin op = C_READ; nd = $urandom_range(1, 4); end
                4: begin op = C_PROG; nd = $urandom_range(1, 4); end
                default: begin
                    do op = 8'($urandom_range(0, 255));
                    while (op inside {C_WREN, C_WRDI, C_RDSR, C_READ, C_PROG});
                    nd = $urandom_range(0, 2);
                end
            endcase
            txn($sformatf("rnd%0d_op%02h", t, op), op, ad, nd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
